// File: rtl/fpga_bringup_sequencer.sv
// FPGA bring-up controller: holds x_heep_system in reset until the clock wizard is locked and the
// reset button is released. It then samples the boot straps at reset release and captures the exit result.
//
// state     | meaning
// WAIT_LOCK | reset asserted; waiting for lock with the button released
// HOLD      | reset asserted; counting HOLD_CYCLES
// RUN       | reset released; waiting for exit_valid_i
// DONE      | reset released; exit result captured and held
module fpga_bringup_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES      = 1000,
    parameter int unsigned HOLD_CYCLES          = 64,
    parameter bit          BTN_ACTIVE_HIGH      = 1'b1,
    parameter int unsigned CLK_LED_COUNT_LENGTH = 27
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pll_locked_i,
    input  logic        btn_rst_i,
    input  logic        boot_select_i,
    input  logic        execute_from_flash_i,
    input  logic        exit_valid_i,
    input  logic [31:0] exit_value_i,
    output logic        sys_rst_no,
    output logic        boot_select_o,
    output logic        execute_from_flash_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o,
    output logic [1:0]  status_o,
    output logic        rst_led_o,
    output logic        clk_led_o
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'b00,
        HOLD      = 2'b01,
        RUN       = 2'b10,
        DONE      = 2'b11
    } state_t;

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned LED_W  = CLK_LED_COUNT_LENGTH;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [LED_W-1:0]  LED_ONE   = LED_W'(1);
    localparam logic              BTN_IDLE  = ~BTN_ACTIVE_HIGH;

    logic [1:0]        lock_sync;
    logic [1:0]        btn_sync;
    logic [1:0]        boot_sync;
    logic [1:0]        flash_sync;
    logic [DB_W-1:0]   db_cnt;
    logic              btn_level;
    logic [HOLD_W-1:0] hold_cnt;
    logic [LED_W-1:0]  led_cnt;
    state_t            state_q;
    state_t            state_next;
    logic              abort;
    logic              hold_done;
    logic              exit_take;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_sync  <= '0;
            btn_sync   <= '0;
            boot_sync  <= '0;
            flash_sync <= '0;
        end else begin
            lock_sync  <= {lock_sync[0], pll_locked_i};
            btn_sync   <= {btn_sync[0], btn_rst_i};
            boot_sync  <= {boot_sync[0], boot_select_i};
            flash_sync <= {flash_sync[0], execute_from_flash_i};
        end
    end

    // Accepted level only flips after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_cnt    <= '0;
            btn_level <= BTN_IDLE;
        end else if (btn_sync[1] == btn_level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt    <= '0;
            btn_level <= btn_sync[1];
        end else begin
            db_cnt <= db_cnt + DB_ONE;
        end
    end

    assign abort = !lock_sync[1] || (btn_level == BTN_ACTIVE_HIGH);

    always_comb begin
        state_next = state_q;
        hold_done  = 1'b0;
        exit_take  = 1'b0;
        if (abort) begin
            state_next = WAIT_LOCK;
        end else begin
            case (state_q)
                WAIT_LOCK: state_next = HOLD;
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_next = RUN;
                        hold_done  = 1'b1;
                    end
                end
                RUN: begin
                    if (exit_valid_i) begin
                        state_next = DONE;
                        exit_take  = 1'b1;
                    end
                end
                DONE:    state_next = DONE;
                default: state_next = WAIT_LOCK;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q              <= WAIT_LOCK;
            hold_cnt             <= '0;
            sys_rst_no           <= 1'b0;
            boot_select_o        <= 1'b0;
            execute_from_flash_o <= 1'b0;
            exit_valid_o         <= 1'b0;
            exit_value_o         <= '0;
        end else begin
            state_q    <= state_next;
            hold_cnt   <= (state_q == HOLD && state_next == HOLD) ? hold_cnt + HOLD_ONE : '0;
            sys_rst_no <= (state_next == RUN) || (state_next == DONE);
            // Exit capture is cleared on reset release so a stale result never survives a re-boot.
            if (hold_done) begin
                boot_select_o        <= boot_sync[1];
                execute_from_flash_o <= flash_sync[1];
                exit_valid_o         <= 1'b0;
                exit_value_o         <= '0;
            end else if (exit_take) begin
                exit_valid_o <= 1'b1;
                exit_value_o <= exit_value_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            led_cnt <= '0;
        end else begin
            led_cnt <= led_cnt + LED_ONE;
        end
    end

    assign status_o  = state_q;
    assign rst_led_o = sys_rst_no;
    assign clk_led_o = led_cnt[LED_W-1];

endmodule
